addsub_accumulator: RTL and testbench

//  Command-driven accumulator controller wrapped around the 4-bit adder/subtractor datapath.

---
 rtl/addsub_pkg.sv | 14 +
 rtl/addsub_sat.sv | 24 ++
 rtl/addsub_accumulator.sv | 124 ++++++++++++
 tb/tb_addsub_accumulator.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/addsub_pkg.sv
// Shared command encodings and controller state type for the add/sub accumulator.
package addsub_pkg;

    localparam logic [1:0] OP_LOAD  = 2'b00;
    localparam logic [1:0] OP_ADD   = 2'b01;
    localparam logic [1:0] OP_SUB   = 2'b10;
    localparam logic [1:0] OP_CLEAR = 2'b11;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EXEC = 1'b1
    } state_t;

endpackage

// File: rtl/addsub_sat.sv
// Maps the external adder's sum/overflow to the next accumulator value.
// Saturates on signed overflow when SATURATE_EN is defined, otherwise passes the sum through.
module addsub_sat #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] sum_i,
    input  logic             v_i,
    output logic [WIDTH-1:0] acc_next_o
);

`ifdef SATURATE_EN
    localparam bit SAT_ON = 1'b1;
`else
    localparam bit SAT_ON = 1'b0;
`endif

    logic [WIDTH-1:0] sat_val;

    // A wrapped sum with MSB set means the true result overflowed positively.
    assign sat_val    = sum_i[WIDTH-1] ? {1'b0, {(WIDTH-1){1'b1}}}
                                       : {1'b1, {(WIDTH-1){1'b0}}};
    assign acc_next_o = (SAT_ON && v_i) ? sat_val : sum_i;

endmodule

// File: rtl/addsub_accumulator.sv
// Command-driven accumulator controller around an external add/sub datapath.
// Optional saturation on signed overflow is enabled with the SATURATE_EN macro.
module addsub_accumulator
    import addsub_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_op,
    input  logic [WIDTH-1:0] cmd_data,
    output logic [WIDTH-1:0] add_a,
    output logic [WIDTH-1:0] add_b,
    output logic             add_m,
    input  logic [WIDTH-1:0] add_s,
    input  logic             add_cout,
    input  logic             add_v,
    output logic [WIDTH-1:0] acc,
    output logic             res_valid,
    output logic             carry,
    output logic             ovf,
    output logic             ovf_sticky,
    output logic             zero
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             m_q, m_d;
    logic             carry_q, carry_d;
    logic             ovf_q, ovf_d;
    logic             sticky_q, sticky_d;
    logic             rv_q, rv_d;
    logic [WIDTH-1:0] sat_acc;

    addsub_sat #(.WIDTH(WIDTH)) u_sat (
        .sum_i      (add_s),
        .v_i        (add_v),
        .acc_next_o (sat_acc)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            acc_q    <= '0;
            b_q      <= '0;
            m_q      <= 1'b0;
            carry_q  <= 1'b0;
            ovf_q    <= 1'b0;
            sticky_q <= 1'b0;
            rv_q     <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            b_q      <= b_d;
            m_q      <= m_d;
            carry_q  <= carry_d;
            ovf_q    <= ovf_d;
            sticky_q <= sticky_d;
            rv_q     <= rv_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        b_d      = b_q;
        m_d      = m_q;
        carry_d  = carry_q;
        ovf_d    = ovf_q;
        sticky_d = sticky_q;
        rv_d     = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_LOAD: begin
                            acc_d   = cmd_data;
                            carry_d = 1'b0;
                            ovf_d   = 1'b0;
                            rv_d    = 1'b1;
                        end
                        OP_CLEAR: begin
                            acc_d    = '0;
                            carry_d  = 1'b0;
                            ovf_d    = 1'b0;
                            sticky_d = 1'b0;
                            rv_d     = 1'b1;
                        end
                        default: begin
                            // ADD and SUB: latch the operand and let the adder settle for one cycle.
                            b_d     = cmd_data;
                            m_d     = (cmd_op == OP_SUB);
                            state_d = ST_EXEC;
                        end
                    endcase
                end
            end
            ST_EXEC: begin
                acc_d    = sat_acc;
                carry_d  = add_cout;
                ovf_d    = add_v;
                sticky_d = sticky_q | add_v;
                rv_d     = 1'b1;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign cmd_ready  = (state_q == ST_IDLE);
    assign zero       = (acc_q == '0);
    assign add_a      = acc_q;
    assign add_b      = b_q;
    assign add_m      = m_q;
    assign acc        = acc_q;
    assign res_valid  = rv_q;
    assign carry      = carry_q;
    assign ovf        = ovf_q;
    assign ovf_sticky = sticky_q;

endmodule

// File: tb/tb_addsub_accumulator.sv
// Bench for addsub_accumulator with a 4-bit add/sub adder modelled alongside; honours SATURATE_EN.
module tb_addsub_accumulator;

    localparam logic [1:0] LD  = 2'b00;
    localparam logic [1:0] AD  = 2'b01;
    localparam logic [1:0] SB  = 2'b10;
    localparam logic [1:0] CLR = 2'b11;

    logic       clk = 1'b0;
    logic       reset;
    logic       cmd_valid, cmd_ready;
    logic [1:0] cmd_op;
    logic [3:0] cmd_data, add_a, add_b, add_s, acc;
    logic       add_m, add_cout, add_v, res_valid, carry, ovf, ovf_sticky, zero;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    // External 4-bit adder/subtractor: A + (B ^ M) + M.
    logic [3:0] bx;
    logic [4:0] full;
    assign bx       = add_m ? ~add_b : add_b;
    assign full     = {1'b0, add_a} + {1'b0, bx} + {4'b0, add_m};
    assign add_s    = full[3:0];
    assign add_cout = full[4];
    assign add_v    = (add_a[3] == bx[3]) && (add_s[3] != add_a[3]);

    addsub_accumulator #(.WIDTH(4)) dut (
        .clk        (clk),
        .reset      (reset),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_data   (cmd_data),
        .add_a      (add_a),
        .add_b      (add_b),
        .add_m      (add_m),
        .add_s      (add_s),
        .add_cout   (add_cout),
        .add_v      (add_v),
        .acc        (acc),
        .res_valid  (res_valid),
        .carry      (carry),
        .ovf        (ovf),
        .ovf_sticky (ovf_sticky),
        .zero       (zero)
    );

    task automatic chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference arithmetic on integers: unsigned for carry, signed range for overflow.
    typedef struct packed {
        logic [3:0] acc;
        logic       c;
        logic       v;
    } res_t;

    function automatic res_t arith(input int a, input int b, input bit sub);
        res_t o;
        int sa, sb, r, s;
        sa = (a > 7) ? a - 16 : a;
        sb = (b > 7) ? b - 16 : b;
        if (sub) begin
            s   = a - b;
            r   = sa - sb;
            o.c = (a >= b);
        end else begin
            s   = a + b;
            r   = sa + sb;
            o.c = (s > 15);
        end
        o.v   = (r > 7) || (r < -8);
        o.acc = 4'(s & 15);
`ifdef SATURATE_EN
        if (o.v) o.acc = (r > 7) ? 4'd7 : 4'd8;
`endif
        return o;
    endfunction

    // Behavioural model: one pending ADD/SUB resolves on the next edge.
    logic [3:0] m_acc, m_b;
    logic       m_carry, m_ovf, m_sticky, m_sub, m_pend, m_rv;
    res_t       m_res;
    assign m_res = arith(int'(m_acc), int'(m_b), m_sub);

    always @(posedge clk or posedge reset) begin
        if (reset) begin
            m_acc <= 4'd0; m_b <= 4'd0; m_carry <= 1'b0; m_ovf <= 1'b0;
            m_sticky <= 1'b0; m_sub <= 1'b0; m_pend <= 1'b0; m_rv <= 1'b0;
        end else begin
            m_rv <= 1'b0;
            if (m_pend) begin
                m_acc    <= m_res.acc;
                m_carry  <= m_res.c;
                m_ovf    <= m_res.v;
                m_sticky <= m_sticky | m_res.v;
                m_rv     <= 1'b1;
                m_pend   <= 1'b0;
            end else if (cmd_valid) begin
                if (cmd_op == LD) begin
                    m_acc <= cmd_data; m_carry <= 1'b0; m_ovf <= 1'b0; m_rv <= 1'b1;
                end else if (cmd_op == CLR) begin
                    m_acc <= 4'd0; m_carry <= 1'b0; m_ovf <= 1'b0; m_sticky <= 1'b0; m_rv <= 1'b1;
                end else begin
                    m_b <= cmd_data; m_sub <= (cmd_op == SB); m_pend <= 1'b1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (!reset) begin
            chk("acc",        acc,        m_acc);
            chk("res_valid",  res_valid,  m_rv);
            chk("carry",      carry,      m_carry);
            chk("ovf",        ovf,        m_ovf);
            chk("ovf_sticky", ovf_sticky, m_sticky);
            chk("zero",       zero,       m_acc == 4'd0);
            chk("cmd_ready",  cmd_ready,  !m_pend);
            chk("add_a",      add_a,      m_acc);
            chk("add_b",      add_b,      m_b);
            chk("add_m",      add_m,      m_sub);
        end
    end

    // Called at a negedge; returns at the negedge following the accepting edge.
    task automatic send(input logic [1:0] op, input logic [3:0] data);
        int n = 0;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_data  = data;
        while (!cmd_ready && n < 8) begin
            @(negedge clk);
            n++;
        end
        if (!cmd_ready) chk("accept_timeout", 8'd1, 8'd0);
        @(posedge clk);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    task automatic wait_result(input int exp_wait);
        int n = 0;
        while (!res_valid && n < 6) begin
            @(negedge clk);
            n++;
        end
        chk("latency", 8'(n), 8'(exp_wait));
    endtask

    initial begin
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_data = 4'd0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_acc", acc, 8'd0);
        chk("rst_zero", zero, 8'd1);
        chk("rst_ready", cmd_ready, 8'd1);
        chk("rst_rv", res_valid, 8'd0);
        chk("rst_sticky", ovf_sticky, 8'd0);

        send(LD, 4'b0101); wait_result(0);
        send(AD, 4'b0011); wait_result(1);
`ifdef SATURATE_EN
        chk("add_ovf_acc", acc, 8'b0111);
`else
        chk("add_ovf_acc", acc, 8'b1000);
`endif
        chk("add_ovf_carry", carry, 8'd0);
        chk("add_ovf_ovf", ovf, 8'd1);
        chk("add_ovf_sticky", ovf_sticky, 8'd1);

        send(LD, 4'b0011); wait_result(0);
        send(SB, 4'b0101); wait_result(1);
        chk("sub_acc", acc, 8'b1110);
        chk("sub_carry", carry, 8'd0);
        chk("sub_ovf", ovf, 8'd0);
        chk("sub_zero", zero, 8'd0);
        chk("sub_sticky", ovf_sticky, 8'd1);

        send(LD, 4'b0000); wait_result(0);
        send(SB, 4'b0000); wait_result(1);
        chk("sub0_acc", acc, 8'd0);
        chk("sub0_carry", carry, 8'd1);
        chk("sub0_zero", zero, 8'd1);
        send(CLR, 4'd0); wait_result(0);
        chk("clr_sticky", ovf_sticky, 8'd0);

        // Command held through EXEC is taken exactly once, at the result cycle.
        send(LD, 4'd2); wait_result(0);
        send(AD, 4'd1);
        chk("exec_ready", cmd_ready, 8'd0);
        send(LD, 4'd9);
        chk("b2b_acc", acc, 8'd9);
        @(negedge clk);
        chk("b2b_once", res_valid, 8'd0);

        // Reset during EXEC discards the operation.
        send(AD, 4'd4);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        chk("rexec_acc", acc, 8'd0);
        chk("rexec_rv", res_valid, 8'd0);
        chk("rexec_ready", cmd_ready, 8'd1);
        @(negedge clk);
        chk("rexec_rv2", res_valid, 8'd0);

        repeat (400) begin
            if ($urandom_range(0, 3) == 0) @(negedge clk);
            send(2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)));
        end
        repeat (4) @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
